// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter and in-order pipeline sharing one single-port RAM between two requesters
module mem_port_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int CNT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arb_en,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [WIDTH-1:0]      req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [WIDTH-1:0]      req1_wdata,
  output logic                  rsp0_valid,
  output logic [WIDTH-1:0]      rsp0_rdata,
  output logic                  rsp1_valid,
  output logic [WIDTH-1:0]      rsp1_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata,
  output logic [CNT_WIDTH-1:0]  conflict_cnt
);
  logic last_grant;
  logic mem_tag;
  logic [1:0] rsp_v;
  logic accept;
  assign req0_ready = rst_n & arb_en & req0_valid & (!req1_valid | last_grant);
  assign req1_ready = rst_n & arb_en & req1_valid & (!req0_valid | !last_grant);
  assign accept = req0_ready | req1_ready;
  assign rsp0_valid = rsp_v[0];
  assign rsp1_valid = rsp_v[1];
  assign rsp0_rdata = rsp_v[0] ? mem_rdata : '0;
  assign rsp1_rdata = rsp_v[1] ? mem_rdata : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant   <= 1'b1;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_tag      <= 1'b0;
      rsp_v        <= '0;
      conflict_cnt <= '0;
    end else begin
      mem_en <= accept;
      mem_we <= accept & (req1_ready ? req1_we : req0_we);
      if (accept) begin
        last_grant <= req1_ready;
        mem_tag    <= req1_ready;
        mem_addr   <= req1_ready ? req1_addr : req0_addr;
        mem_wdata  <= req1_ready ? req1_wdata : req0_wdata;
      end
      rsp_v <= {mem_en & !mem_we & mem_tag, mem_en & !mem_we & !mem_tag};
      if (req0_valid & req1_valid & ~&conflict_cnt) conflict_cnt <= conflict_cnt + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with a behavioural RAM feeding mem_rdata
module tb_mem_port_arbiter;
  logic clk = 0, rst_n = 0, arb_en = 0;
  logic req0_valid = 0, req0_we = 0, req1_valid = 0, req1_we = 0;
  logic [4:0] req0_addr = 0, req1_addr = 0;
  logic [7:0] req0_wdata = 0, req1_wdata = 0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_en, mem_we;
  logic [7:0] rsp0_rdata, rsp1_rdata, mem_wdata, conflict_cnt;
  logic [7:0] mem_rdata = 0;
  logic [4:0] mem_addr;
  logic [7:0] ram [32];
  logic [7:0] shadow [32];
  typedef struct {int id; logic [7:0] data; int cyc;} exp_t;
  exp_t q[$];
  int cyc = 0, checks = 0, errors = 0;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (mem_en) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    else mem_rdata <= ram[mem_addr];
  end

  // Responses are checked before new accepts are recorded; latency is always two cycles.
  always @(negedge clk) begin
    if (!rst_n) q.delete();
    else begin
      if (rsp0_valid || rsp1_valid) begin
        checks++;
        if (rsp0_valid && rsp1_valid) begin
          errors++; $display("FAIL rsp_both: rsp0_valid=1 rsp1_valid=1, required only one");
        end else if (q.size() == 0) begin
          errors++; $display("FAIL rsp_unexpected: rsp%0d_valid=1 at cycle %0d, required no response", rsp1_valid, cyc);
        end else begin
          exp_t e;
          int gid;
          logic [7:0] gd;
          e = q.pop_front();
          gid = rsp1_valid ? 1 : 0;
          gd = rsp1_valid ? rsp1_rdata : rsp0_rdata;
          if (gid !== e.id || gd !== e.data || cyc !== e.cyc + 2) begin
            errors++;
            $display("FAIL rsp: got id=%0d data=%h cycle=%0d, required id=%0d data=%h cycle=%0d", gid, gd, cyc, e.id, e.data, e.cyc + 2);
          end
        end
      end
      if (req0_valid && req0_ready) begin
        if (req0_we) shadow[req0_addr] = req0_wdata;
        else q.push_back('{0, shadow[req0_addr], cyc});
      end
      if (req1_valid && req1_ready) begin
        if (req1_we) shadow[req1_addr] = req1_wdata;
        else q.push_back('{1, shadow[req1_addr], cyc});
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0_valid = 0; req1_valid = 0; req0_we = 0; req1_we = 0;
  endtask

  task automatic pulse_reset();
    idle(); rst_n = 0; step(2); rst_n = 1;
  endtask

  task automatic drain(string name);
    step(3);
    checks++;
    if (q.size() !== 0) begin errors++; $display("FAIL %s_drain: %0d responses outstanding, required 0", name, q.size()); end
  endtask

  task automatic test_reset();
    req0_valid = 1; req1_valid = 1; arb_en = 1;
    step(3);
    checks++;
    if ({req0_ready, req1_ready, mem_en, rsp0_valid, rsp1_valid} !== 5'b0 || conflict_cnt !== 0) begin
      errors++;
      $display("FAIL reset: ready=%b%b mem_en=%b rsp=%b%b cnt=%0d, required all 0", req0_ready, req1_ready, mem_en, rsp0_valid, rsp1_valid, conflict_cnt);
    end
    idle(); rst_n = 1; step();
  endtask

  task automatic test_write_read();
    req0_valid = 1; req0_we = 1; req0_addr = 5; req0_wdata = 8'hA5;
    #1;
    checks++;
    if (req0_ready !== 1) begin errors++; $display("FAIL wr_ready: req0_ready=%b, required 1", req0_ready); end
    step();
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 5'd5, 8'hA5}) begin
      errors++; $display("FAIL wr_port: en=%b we=%b addr=%0d wdata=%h, required 1 1 5 a5", mem_en, mem_we, mem_addr, mem_wdata);
    end
    req0_we = 0;
    step();
    idle();
    checks++;
    if ({mem_en, mem_we, mem_addr} !== {2'b10, 5'd5}) begin
      errors++; $display("FAIL rd_port: en=%b we=%b addr=%0d, required 1 0 5", mem_en, mem_we, mem_addr);
    end
    step();
    checks++;
    if (rsp0_valid !== 1 || rsp0_rdata !== 8'hA5 || rsp1_valid !== 0 || rsp1_rdata !== 0 || mem_en !== 0) begin
      errors++;
      $display("FAIL rd_rsp: rsp0=%b/%h rsp1=%b/%h mem_en=%b, required 1/a5 0/00 0", rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata, mem_en);
    end
    drain("write_read");
  endtask

  task automatic test_round_robin();
    int g = 0;
    pulse_reset();
    arb_en = 1;
    req0_valid = 1; req0_addr = 3; req1_valid = 1; req1_addr = 20;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
        errors++; $display("FAIL rr_grant%0d: ready=%b%b, required grant %0d", i, req1_ready, req0_ready, g);
      end
      g = 1 - g;
      step();
    end
    idle();
    checks++;
    if (conflict_cnt !== 6) begin errors++; $display("FAIL rr_cnt: conflict_cnt=%0d, required 6", conflict_cnt); end
    drain("round_robin");
  endtask

  task automatic test_arb_en();
    arb_en = 0; req1_valid = 1; req1_addr = 7;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (req1_ready !== 0 || mem_en !== 0) begin
        errors++; $display("FAIL gate%0d: req1_ready=%b mem_en=%b, required 0 0", i, req1_ready, mem_en);
      end
      step();
    end
    arb_en = 1;
    #1;
    checks++;
    if (req1_ready !== 1) begin errors++; $display("FAIL gate_release: req1_ready=%b, required 1", req1_ready); end
    step();
    idle();
    drain("arb_en");
  endtask

  task automatic test_mid_reset();
    req1_valid = 1; req1_addr = 9;
    #1;
    checks++;
    if (req1_ready !== 1) begin errors++; $display("FAIL mr_accept: req1_ready=%b, required 1", req1_ready); end
    step();
    idle();
    rst_n = 0;
    #1;
    checks++;
    if (mem_en !== 0 || rsp1_valid !== 0) begin
      errors++; $display("FAIL mr_clear: mem_en=%b rsp1_valid=%b, required 0 0", mem_en, rsp1_valid);
    end
    step(2);
    rst_n = 1;
    step(4);
    req0_valid = 1; req1_valid = 1;
    #1;
    checks++;
    if (req0_ready !== 1 || req1_ready !== 0) begin
      errors++; $display("FAIL mr_tie: ready0=%b ready1=%b, required 1 0", req0_ready, req1_ready);
    end
    step();
    idle();
    drain("mid_reset");
  endtask

  task automatic test_saturate();
    pulse_reset();
    arb_en = 0; req0_valid = 1; req1_valid = 1;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (i == 254) begin
        checks++;
        if (conflict_cnt !== 254) begin errors++; $display("FAIL sat_254: conflict_cnt=%0d, required 254", conflict_cnt); end
      end
      if (i == 255 || i == 300) begin
        checks++;
        if (conflict_cnt !== 255 || mem_en !== 0) begin
          errors++; $display("FAIL sat_%0d: conflict_cnt=%0d mem_en=%b, required 255 0", i, conflict_cnt, mem_en);
        end
      end
    end
    idle();
    drain("saturate");
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      ram[i] = 8'(i) ^ 8'h3C;
      shadow[i] = 8'(i) ^ 8'h3C;
    end
    test_reset();
    test_write_read();
    test_round_robin();
    test_arb_en();
    test_mid_reset();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
